// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush scheduler: arbitrates jump, multi-cycle EX, fetch-bus and interrupt stalls.
// Optional statistics counters are enabled by defining CTRL_STAT_EN.
module pipe_hold_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_bus_i,
    input  logic        int_req_i,
    input  logic        int_done_i,
    output logic        int_grant_o,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        stall_timeout_o
`ifdef CTRL_STAT_EN
    ,
    output logic [31:0] stat_stall_o,
    output logic [31:0] stat_flush_o
`endif
);

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_INT
    } state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] flushCnt_q, flushCnt_d;
    logic [TO_W-1:0] toCnt_q, toCnt_d;
    logic            timeout_q, timeout_d;

    // A redirect from EX always wins and grabs the whole front end for the current cycle.
    always_comb begin
        hold_flag_o = HOLD_NONE;
        jump_flag_o = 1'b0;
        jump_addr_o = '0;
        int_grant_o = 1'b0;
        if (!rst) begin
            hold_flag_o = HOLD_ID;
        end else if (jump_flag_i) begin
            hold_flag_o = HOLD_ID;
            jump_flag_o = 1'b1;
            jump_addr_o = jump_addr_i;
        end else if (state_q == ST_FLUSH) begin
            hold_flag_o = HOLD_ID;
        end else if (state_q == ST_INT) begin
            hold_flag_o = HOLD_ID;
            int_grant_o = 1'b1;
        end else if (hold_ex_i) begin
            hold_flag_o = HOLD_ID;
        end else if (hold_bus_i) begin
            hold_flag_o = HOLD_PC;
        end
    end

    always_comb begin
        state_d    = state_q;
        flushCnt_d = flushCnt_q;
        if (jump_flag_i) begin
            if (FLUSH_CYCLES > 1) begin
                state_d    = ST_FLUSH;
                flushCnt_d = FC_LOAD;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (int_req_i && !hold_ex_i) state_d = ST_INT;
                end
                ST_FLUSH: begin
                    flushCnt_d = flushCnt_q - 1'b1;
                    if (flushCnt_q <= FC_W'(1)) state_d = ST_RUN;
                end
                ST_INT: begin
                    if (int_done_i || !int_req_i) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Watchdog saturates so a stuck bus can never wrap the count back below the limit.
    always_comb begin
        toCnt_d = '0;
        if (hold_bus_i) toCnt_d = (toCnt_q == TO_MAX) ? toCnt_q : toCnt_q + 1'b1;
        timeout_d = timeout_q | (toCnt_d == TO_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            flushCnt_q <= '0;
            toCnt_q    <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flushCnt_q <= flushCnt_d;
            toCnt_q    <= toCnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign stall_timeout_o = timeout_q;

`ifdef CTRL_STAT_EN
    logic [31:0] statStall_q, statFlush_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            statStall_q <= '0;
            statFlush_q <= '0;
        end else begin
            statStall_q <= statStall_q + {31'd0, (hold_flag_o != HOLD_NONE)};
            statFlush_q <= statFlush_q + {31'd0, jump_flag_i};
        end
    end

    assign stat_stall_o = statStall_q;
    assign stat_flush_o = statFlush_q;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Testbench for pipe_hold_ctrl: directed scenarios with literal expectations plus a long
// randomized run compared every cycle against a behavioural model of the scheduling rules.
module tb_pipe_hold_ctrl;

    localparam int FC = 2;
    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_ex_i;
    logic        hold_bus_i;
    logic        int_req_i;
    logic        int_done_i;
    logic        int_grant_o;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        stall_timeout_o;
`ifdef CTRL_STAT_EN
    logic [31:0] stat_stall_o;
    logic [31:0] stat_flush_o;
`endif

    int checks = 0;
    int errors = 0;

    pipe_hold_ctrl #(.FLUSH_CYCLES(FC), .TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .hold_ex_i       (hold_ex_i),
        .hold_bus_i      (hold_bus_i),
        .int_req_i       (int_req_i),
        .int_done_i      (int_done_i),
        .int_grant_o     (int_grant_o),
        .hold_flag_o     (hold_flag_o),
        .jump_flag_o     (jump_flag_o),
        .jump_addr_o     (jump_addr_o),
        .stall_timeout_o (stall_timeout_o)
`ifdef CTRL_STAT_EN
        ,
        .stat_stall_o    (stat_stall_o),
        .stat_flush_o    (stat_flush_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge so the DUT never sees a race.
    task automatic applyStimulus(input logic r, input logic jf, input logic [31:0] a,
                                 input logic ex, input logic bus, input logic req,
                                 input logic done);
        @(posedge clk);
        #1;
        rst         = r;
        jump_flag_i = jf;
        jump_addr_i = a;
        hold_ex_i   = ex;
        hold_bus_i  = bus;
        int_req_i   = req;
        int_done_i  = done;
    endtask

    // Model state: cycles of forced Hold_Id still owed to a past jump, whether the interrupt
    // unit currently owns the pipeline, the current bus-stall run length and the sticky flag.
    int          flushRemain = 0;
    bit          intOwned    = 0;
    int          busRun      = 0;
    bit          stickyTo    = 0;
    int unsigned mStall      = 0;
    int unsigned mFlush      = 0;

    // Compare process: on every falling edge predict all outputs, compare, then advance.
    always @(negedge clk) begin
        logic [2:0]  eHold;
        logic        eJump;
        logic [31:0] eAddr;
        logic        eGrant;
        eHold  = 3'd0;
        eJump  = 1'b0;
        eAddr  = 32'd0;
        eGrant = 1'b0;
        if (!rst) begin
            eHold = 3'd3;
        end else if (jump_flag_i) begin
            eHold = 3'd3;
            eJump = 1'b1;
            eAddr = jump_addr_i;
        end else if (flushRemain > 0) begin
            eHold = 3'd3;
        end else if (intOwned) begin
            eHold  = 3'd3;
            eGrant = 1'b1;
        end else if (hold_ex_i) begin
            eHold = 3'd3;
        end else if (hold_bus_i) begin
            eHold = 3'd1;
        end

        checkOutput("model_hold", 32'(hold_flag_o), 32'(eHold));
        checkOutput("model_jump_flag", 32'(jump_flag_o), 32'(eJump));
        checkOutput("model_jump_addr", jump_addr_o, eAddr);
        checkOutput("model_grant", 32'(int_grant_o), 32'(eGrant));
        checkOutput("model_timeout", 32'(stall_timeout_o), 32'(stickyTo));
`ifdef CTRL_STAT_EN
        checkOutput("model_stat_stall", stat_stall_o, mStall);
        checkOutput("model_stat_flush", stat_flush_o, mFlush);
`endif

        if (!rst) begin
            flushRemain = 0;
            intOwned    = 0;
            busRun      = 0;
            stickyTo    = 0;
            mStall      = 0;
            mFlush      = 0;
        end else begin
            if (jump_flag_i) begin
                if (FC > 1) begin
                    flushRemain = FC - 1;
                    intOwned    = 0;
                end
            end else if (flushRemain > 0) begin
                flushRemain--;
            end else if (intOwned) begin
                if (int_done_i || !int_req_i) intOwned = 0;
            end else if (int_req_i && !hold_ex_i) begin
                intOwned = 1;
            end
            busRun = hold_bus_i ? ((busRun < TO) ? busRun + 1 : TO) : 0;
            if (busRun == TO) stickyTo = 1;
            if (eHold != 3'd0) mStall++;
            if (jump_flag_i) mFlush++;
        end
    end

    initial begin
        logic        r, jf, ex, bus, req, done;
        logic [31:0] a;
        rst         = 1'b0;
        jump_flag_i = 1'b0;
        jump_addr_i = 32'd0;
        hold_ex_i   = 1'b0;
        hold_bus_i  = 1'b0;
        int_req_i   = 1'b0;
        int_done_i  = 1'b0;

        // Reset held three cycles, then released.
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t1_reset_hold", 32'(hold_flag_o), 32'd3);
        checkOutput("t1_reset_jump", 32'(jump_flag_o), 32'd0);
        checkOutput("t1_reset_timeout", 32'(stall_timeout_o), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("t1_release_hold", 32'(hold_flag_o), 32'd0);

        // Single jump: redirect visible the same cycle, Hold_Id for two cycles total.
        applyStimulus(1, 1, 32'h0000_0100, 0, 0, 0, 0);
        #2;
        checkOutput("t2_jump_flag", 32'(jump_flag_o), 32'd1);
        checkOutput("t2_jump_addr", jump_addr_o, 32'h0000_0100);
        checkOutput("t2_hold_c0", 32'(hold_flag_o), 32'd3);
        applyStimulus(1, 0, 32'h0000_0100, 0, 0, 0, 0);
        #2;
        checkOutput("t2_hold_c1", 32'(hold_flag_o), 32'd3);
        checkOutput("t2_addr_c1", jump_addr_o, 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("t2_hold_c2", 32'(hold_flag_o), 32'd0);

        // Back-to-back jumps extend the flush window.
        applyStimulus(1, 1, 32'h0000_0200, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h0000_0300, 0, 0, 0, 0);
        #2 checkOutput("t3_addr_c1", jump_addr_o, 32'h0000_0300);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("t3_hold_c2", 32'(hold_flag_o), 32'd3);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("t3_hold_c3", 32'(hold_flag_o), 32'd0);

        // Arbitration between EX and bus stalls.
        applyStimulus(1, 0, 0, 1, 1, 0, 0);
        #2 checkOutput("t4_ex_bus", 32'(hold_flag_o), 32'd3);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        #2 checkOutput("t4_bus", 32'(hold_flag_o), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("t4_none", 32'(hold_flag_o), 32'd0);

        // Interrupt is not granted while EX is busy; granted the cycle after EX frees up.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 1, 0, 1, 0);
            #2 checkOutput("t5_no_grant", 32'(int_grant_o), 32'd0);
        end
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        #2 checkOutput("t5_grant_wait", 32'(int_grant_o), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0);
        #2;
        checkOutput("t5_grant", 32'(int_grant_o), 32'd1);
        checkOutput("t5_grant_hold", 32'(hold_flag_o), 32'd3);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        #2 checkOutput("t5_done_cycle", 32'(int_grant_o), 32'd1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t5_after_grant", 32'(int_grant_o), 32'd0);
        checkOutput("t5_after_hold", 32'(hold_flag_o), 32'd0);

        // Watchdog: seven stall cycles are tolerated, eight trip the sticky flag.
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (7) applyStimulus(1, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("t6_seven", 32'(stall_timeout_o), 32'd0);
        repeat (8) applyStimulus(1, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("t6_eight", 32'(stall_timeout_o), 32'd1);
`ifdef CTRL_STAT_EN
        checkOutput("t6_stat_stall", stat_stall_o, 32'd15);
        checkOutput("t6_stat_flush", stat_flush_o, 32'd0);
`endif
        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        #2 checkOutput("t6_sticky", 32'(stall_timeout_o), 32'd1);

        // Randomized run: stalls and interrupt requests are bursty so long runs occur.
        for (int i = 0; i < 4000; i++) begin
            r    = ($urandom_range(0, 599) != 0);
            jf   = ($urandom_range(0, 9) == 0);
            a    = $urandom();
            ex   = ($urandom_range(0, 5) == 0);
            bus  = hold_bus_i ? ($urandom_range(0, 11) != 0) : ($urandom_range(0, 5) == 0);
            req  = int_req_i ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 7) == 0);
            done = req && ($urandom_range(0, 4) == 0);
            applyStimulus(r, jf, a, ex, bus, req, done);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
